// File: rtl/approx_adder_eval_pipe.sv
// Two-stage approximate adder (exact / zero-low / truncated-carry) with running error statistics.
// Latency 2 cycles; a stalled output freezes both stages, and in_ready = !out_valid || out_ready.
module approx_adder_eval_pipe #(
  parameter int W     = 8,
  parameter int TRUNC = 7,
  parameter int CNT_W = 32,
  parameter int SUM_W = 40
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W:0]       sum,
  output logic [W:0]       err,
  input  logic             stat_clear,
  output logic [CNT_W-1:0] stat_samples,
  output logic [CNT_W-1:0] stat_err_cnt,
  output logic [SUM_W-1:0] stat_err_sum,
  output logic [W:0]       stat_err_max
);

  typedef enum logic [1:0] {
    MODE_EXACT = 2'd0,
    MODE_ZLOW  = 2'd1,
    MODE_TRUNC = 2'd2,
    MODE_RSVD  = 2'd3
  } mode_e;

  localparam logic [W:0] KEEP_MASK = ~(((W+1)'(1) << TRUNC) - (W+1)'(1));

  logic             r_s1_vld;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  mode_e            r_mode;
  logic             r_s2_vld;
  logic [W:0]       r_sum;
  logic [W:0]       r_err;
  logic [CNT_W-1:0] r_samples;
  logic [CNT_W-1:0] r_err_cnt;
  logic [SUM_W-1:0] r_err_sum;
  logic [W:0]       r_err_max;

  logic             w_en;
  logic             w_out_hs;
  logic [W:0]       w_exact;
  logic [W-1:0]     w_a_hi;
  logic [W-1:0]     w_b_hi;
  logic [W:0]       w_trunc;
  logic [W:0]       w_sum;
  logic [W:0]       w_err;
  logic [SUM_W:0]   w_err_sum_nxt;

  assign w_en     = !r_s2_vld || out_ready;
  assign w_out_hs = r_s2_vld && out_ready;

  assign w_exact = {1'b0, r_a} + {1'b0, r_b};
  assign w_a_hi  = r_a >> TRUNC;
  assign w_b_hi  = r_b >> TRUNC;
  // Kept region summed on its own, so no carry from the dropped low bits.
  assign w_trunc = ({1'b0, w_a_hi} + {1'b0, w_b_hi}) << TRUNC;

  always_comb begin
    w_sum = w_exact;
    case (r_mode)
      MODE_ZLOW:  w_sum = w_exact & KEEP_MASK;
      MODE_TRUNC: w_sum = w_trunc;
      default:    w_sum = w_exact;
    endcase
    w_err = w_exact - w_sum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vld <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_mode   <= MODE_EXACT;
      r_s2_vld <= 1'b0;
      r_sum    <= '0;
      r_err    <= '0;
    end else if (w_en) begin
      r_s1_vld <= in_valid;
      if (in_valid) begin
        r_a    <= a;
        r_b    <= b;
        r_mode <= mode_e'(mode);
      end
      r_s2_vld <= r_s1_vld;
      if (r_s1_vld) begin
        r_sum <= w_sum;
        r_err <= w_err;
      end
    end
  end

  // One extra bit catches accumulator overflow for saturation.
  assign w_err_sum_nxt = {1'b0, r_err_sum} + {1'b0, SUM_W'(r_err)};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_samples <= '0;
      r_err_cnt <= '0;
      r_err_sum <= '0;
      r_err_max <= '0;
    end else if (stat_clear) begin
      r_samples <= '0;
      r_err_cnt <= '0;
      r_err_sum <= '0;
      r_err_max <= '0;
    end else if (w_out_hs) begin
      if (r_samples != '1) r_samples <= r_samples + CNT_W'(1);
      if ((r_err != '0) && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + CNT_W'(1);
      r_err_sum <= w_err_sum_nxt[SUM_W] ? '1 : w_err_sum_nxt[SUM_W-1:0];
      if (r_err > r_err_max) r_err_max <= r_err;
    end
  end

  assign in_ready     = w_en;
  assign out_valid    = r_s2_vld;
  assign sum          = r_sum;
  assign err          = r_err;
  assign stat_samples = r_samples;
  assign stat_err_cnt = r_err_cnt;
  assign stat_err_sum = r_err_sum;
  assign stat_err_max = r_err_max;

endmodule

// File: tb/tb_approx_adder_eval_pipe.sv
// Bench for approx_adder_eval_pipe: directed vectors, stall/clear/saturation/reset sequences,
// and random traffic scored against an arithmetic reference model.
module tb_approx_adder_eval_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  a = '0;
  logic [7:0]  b = '0;
  logic [1:0]  mode = '0;
  logic        out_ready = 1'b1;
  logic        stat_clear = 1'b0;

  logic        in_ready, out_valid;
  logic [8:0]  sum, err, stat_err_max;
  logic [31:0] stat_samples, stat_err_cnt;
  logic [39:0] stat_err_sum;

  logic        s_in_ready, s_out_valid;
  logic [8:0]  s_sum, s_err, s_err_max;
  logic [3:0]  s_samples, s_err_cnt;
  logic [39:0] s_err_sum;

  logic        t_in_ready, t_out_valid;
  logic [8:0]  t_sum, t_err, t_err_max;
  logic [31:0] t_samples, t_err_cnt;
  logic [39:0] t_err_sum;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  approx_adder_eval_pipe u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .err(err), .stat_clear(stat_clear),
    .stat_samples(stat_samples), .stat_err_cnt(stat_err_cnt), .stat_err_sum(stat_err_sum),
    .stat_err_max(stat_err_max));

  approx_adder_eval_pipe #(.CNT_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready), .a(a), .b(b), .mode(mode),
    .out_valid(s_out_valid), .out_ready(out_ready), .sum(s_sum), .err(s_err), .stat_clear(stat_clear),
    .stat_samples(s_samples), .stat_err_cnt(s_err_cnt), .stat_err_sum(s_err_sum),
    .stat_err_max(s_err_max));

  approx_adder_eval_pipe #(.TRUNC(0)) u_t0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(t_in_ready), .a(a), .b(b), .mode(mode),
    .out_valid(t_out_valid), .out_ready(out_ready), .sum(t_sum), .err(t_err), .stat_clear(stat_clear),
    .stat_samples(t_samples), .stat_err_cnt(t_err_cnt), .stat_err_sum(t_err_sum),
    .stat_err_max(t_err_max));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain arithmetic on the mode rules.
  function automatic int unsigned ref_sum(int unsigned av, int unsigned bv, int unsigned md, int unsigned t);
    int unsigned e = av + bv;
    int unsigned p = 1 << t;
    case (md)
      1:       return e - (e % p);
      2:       return ((av / p) + (bv / p)) * p;
      default: return e;
    endcase
  endfunction

  typedef struct {
    int unsigned s;
    int unsigned e;
    int unsigned x;
  } exp_t;

  exp_t    exp_q[$];
  longint  m_samples = 0, m_cnt = 0, m_sum = 0, m_max = 0;
  longint  q_samples = 0, q_cnt = 0;
  localparam longint CAP32 = 64'hFFFF_FFFF;

  always @(negedge rst_n) begin
    exp_q.delete();
    m_samples = 0; m_cnt = 0; m_sum = 0; m_max = 0;
    q_samples = 0; q_cnt = 0;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      exp_t   cur;
      logic   popped;
      popped = 1'b0;
      check("stat_samples", 64'(stat_samples), 64'(m_samples));
      check("stat_err_cnt", 64'(stat_err_cnt), 64'(m_cnt));
      check("stat_err_sum", 64'(stat_err_sum), 64'(m_sum));
      check("stat_err_max", 64'(stat_err_max), 64'(m_max));
      check("sat_samples", 64'(s_samples), 64'(q_samples));
      check("sat_err_cnt", 64'(s_err_cnt), 64'(q_cnt));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_beat: got sum 0x%0h with no beat outstanding", sum);
        end else begin
          cur = exp_q.pop_front();
          popped = 1'b1;
          check("sb_sum", 64'(sum), 64'(cur.s));
          check("sb_err", 64'(err), 64'(cur.e));
          check("sb_t0_sum", 64'(t_sum), 64'(cur.x));
          check("sb_t0_err", 64'(t_err), 64'd0);
        end
      end
      if (in_valid && in_ready) begin
        exp_t n;
        n.x = int'(a) + int'(b);
        n.s = ref_sum(a, b, mode, 7);
        n.e = n.x - n.s;
        exp_q.push_back(n);
      end
      if (stat_clear) begin
        m_samples = 0; m_cnt = 0; m_sum = 0; m_max = 0;
        q_samples = 0; q_cnt = 0;
      end else if (popped) begin
        if (m_samples < CAP32) m_samples++;
        if (cur.e != 0 && m_cnt < CAP32) m_cnt++;
        m_sum += cur.e;
        if (cur.e > m_max) m_max = cur.e;
        if (q_samples < 15) q_samples++;
        if (cur.e != 0 && q_cnt < 15) q_cnt++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [7:0] va;
    logic [7:0] vb;
    logic [1:0] vm;
    logic [8:0] es;
    logic [8:0] ee;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{8'h7F, 8'h01, 2'd1, 9'h080, 9'h000};
    vecs[1] = '{8'h40, 8'h3F, 2'd1, 9'h000, 9'h07F};
    vecs[2] = '{8'h7F, 8'h01, 2'd2, 9'h000, 9'h080};
    vecs[3] = '{8'hFF, 8'hFF, 2'd0, 9'h1FE, 9'h000};
    vecs[4] = '{8'hFF, 8'hFF, 2'd1, 9'h180, 9'h07E};
    vecs[5] = '{8'hFF, 8'hFF, 2'd2, 9'h100, 9'h0FE};
    vecs[6] = '{8'h12, 8'h34, 2'd3, 9'h046, 9'h000};

    repeat (3) step();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_sum", 64'(sum), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_samples", 64'(stat_samples), 64'd0);
    check("rst_err_max", 64'(stat_err_max), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors, one at a time, latency checked.
    for (int i = 0; i < 7; i++) begin
      step();
      if (i == 2) begin
        check("tp_samples", 64'(stat_samples), 64'd2);
        check("tp_err_cnt", 64'(stat_err_cnt), 64'd1);
        check("tp_err_sum", 64'(stat_err_sum), 64'h7F);
        check("tp_err_max", 64'(stat_err_max), 64'h7F);
      end
      in_valid = 1'b1; a = vecs[i].va; b = vecs[i].vb; mode = vecs[i].vm;
      step();
      in_valid = 1'b0;
      check("vec_lat1_valid", 64'(out_valid), 64'd0);
      step();
      check("vec_lat2_valid", 64'(out_valid), 64'd1);
      check("vec_sum", 64'(sum), 64'(vecs[i].es));
      check("vec_err", 64'(err), 64'(vecs[i].ee));
    end
    step();

    // Backpressure: out_ready low on cycles 3-5.
    stat_clear = 1'b1; step(); stat_clear = 1'b0;
    begin
      int         idx = 0;
      int         got[$];
      logic [8:0] held = '0;
      logic       held_v = 1'b0;
      for (int c = 1; c <= 30 && got.size() < 4; c++) begin
        step();
        out_ready = !(c >= 3 && c <= 5);
        in_valid = (idx < 4); a = 8'(idx + 1); b = 8'h00; mode = 2'd0;
        if (held_v) begin
          check("bp_hold_sum", 64'(sum), 64'(held));
          check("bp_hold_valid", 64'(out_valid), 64'd1);
        end
        held_v = 1'b0;
        @(negedge clk);
        if (out_valid && !out_ready) begin
          check("bp_in_ready", 64'(in_ready), 64'd0);
          held = sum; held_v = 1'b1;
        end
        if (out_valid && out_ready) got.push_back(int'(sum));
        if (in_valid && in_ready) idx++;
      end
      step();
      in_valid = 1'b0; out_ready = 1'b1;
      check("bp_beat_count", 64'(got.size()), 64'd4);
      for (int k = 0; k < got.size(); k++) check("bp_order", 64'(got[k]), 64'(k + 1));
      step();
      check("bp_samples", 64'(stat_samples), 64'd4);
    end

    // Clear coinciding with a handshake.
    step(); in_valid = 1'b1; a = 8'h10; b = 8'h00; mode = 2'd1;
    step(); a = 8'h05;
    step(); in_valid = 1'b0; stat_clear = 1'b1;
    check("clr_beat_err", 64'(err), 64'h10);
    step(); stat_clear = 1'b0;
    check("clr_samples", 64'(stat_samples), 64'd0);
    check("clr_err_sum", 64'(stat_err_sum), 64'd0);
    check("clr_err_max", 64'(stat_err_max), 64'd0);
    check("clr_next_err", 64'(err), 64'h05);
    step();
    check("clr2_samples", 64'(stat_samples), 64'd1);
    check("clr2_err_cnt", 64'(stat_err_cnt), 64'd1);
    check("clr2_err_sum", 64'(stat_err_sum), 64'd5);
    check("clr2_err_max", 64'(stat_err_max), 64'd5);

    // Saturation of the 4-bit counters.
    stat_clear = 1'b1; step(); stat_clear = 1'b0;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1; a = 8'h40; b = 8'h3F; mode = 2'd1;
      step();
    end
    in_valid = 1'b0;
    repeat (3) step();
    check("sat_samples_15", 64'(s_samples), 64'd15);
    check("sat_err_cnt_15", 64'(s_err_cnt), 64'd15);
    check("sat_err_sum", 64'(s_err_sum), 64'd2540);
    check("main_samples_20", 64'(stat_samples), 64'd20);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step();
      in_valid   = ($urandom % 4) != 0;
      out_ready  = ($urandom % 4) != 0;
      a          = 8'($urandom);
      b          = 8'($urandom);
      mode       = 2'($urandom);
      stat_clear = ($urandom % 32) == 0;
    end

    // Asynchronous reset with beats in flight.
    step(); stat_clear = 1'b0; out_ready = 1'b1; in_valid = 1'b1; a = 8'h11; b = 8'h22; mode = 2'd0;
    step(); step();
    check("pre_rst_valid", 64'(out_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_samples", 64'(stat_samples), 64'd0);
    check("arst_err_sum", 64'(stat_err_sum), 64'd0);
    check("arst_sat_samples", 64'(s_samples), 64'd0);
    step(); in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("post_rst_idle", 64'(out_valid), 64'd0);
    end
    in_valid = 1'b1; a = 8'h55; b = 8'h2B; mode = 2'd2;
    step(); in_valid = 1'b0;
    check("post_rst_lat1", 64'(out_valid), 64'd0);
    step();
    check("post_rst_lat2", 64'(out_valid), 64'd1);
    check("post_rst_sum", 64'(sum), 64'h000);
    check("post_rst_err", 64'(err), 64'h080);
    check("t0_sum", 64'(t_sum), 64'h080);
    check("t0_err", 64'(t_err), 64'd0);
    repeat (2) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
